load_store_unit: RTL and testbench

Memory-stage load/store unit between the core's M-stage data port and the Wishbone data bus. It converts the M-stage address, store data and funct3 into a single Wishbone classic transaction with byte selects. It returns aligned, sign- or zero-extended load data and stalls the pipeline until the bus completes. Misaligned accesses are flagged and never reach the bus.

---
 rtl/load_store_unit.sv | 102 ++++++++++
 tb/tb_load_store_unit.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: M-stage loads/stores as single Wishbone classic transactions,
// with byte selects, load extension, misalignment detection and a bus timeout.
module load_store_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_WIDTH       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_read_M,
  input  logic                  i_mem_write_M,
  input  logic [2:0]            i_funct3_MEM,
  input  logic [DATA_WIDTH-1:0] i_data_addr_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  output logic [DATA_WIDTH-1:0] o_read_data_M,
  output logic                  o_stall_M,
  output logic                  o_misaligned_M,
  output logic                  o_bus_err_M,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [3:0]            o_wb_sel,
  output logic [DATA_WIDTH-1:0] o_wb_adr,
  output logic [DATA_WIDTH-1:0] o_wb_dat,
  input  logic [DATA_WIDTH-1:0] i_wb_dat,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_err
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state, state_n;
  logic req, mis, valid, timeout, fail, sx;
  logic [3:0] sel_c, sel_q;
  logic [DATA_WIDTH-1:0] dat_c, dat_q, adr_q, lane, load_c;
  logic we_q, err_q;
  logic [2:0] f3_q;
  logic [1:0] off_q;
  logic [TO_WIDTH-1:0] cnt;
  assign req     = i_mem_read_M | i_mem_write_M;
  assign mis     = req & (i_funct3_MEM[1] ? |i_data_addr_M[1:0] : i_funct3_MEM[0] & i_data_addr_M[0]);
  assign valid   = req & ~mis;
  assign timeout = cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1);
  // err beats a same-cycle ack; timeout only fires when the slave stays silent
  assign fail    = i_wb_err | (~i_wb_ack & timeout);
  assign sel_c   = i_funct3_MEM[1] ? 4'b1111 : i_funct3_MEM[0] ? (i_data_addr_M[1] ? 4'b1100 : 4'b0011)
                 : 4'b0001 << i_data_addr_M[1:0];
  assign dat_c   = i_funct3_MEM[1] ? i_write_data_M : i_funct3_MEM[0] ? {2{i_write_data_M[15:0]}}
                 : {4{i_write_data_M[7:0]}};
  assign sx      = ~f3_q[2];
  assign lane    = i_wb_dat >> {off_q, 3'b000};
  assign load_c  = f3_q[1] ? i_wb_dat : f3_q[0] ? {{16{sx & lane[15]}}, lane[15:0]}
                 : {{24{sx & lane[7]}}, lane[7:0]};
  always_comb begin
    state_n = state == IDLE ? (valid ? BUS : IDLE)
            : state == BUS  ? (i_wb_ack | i_wb_err | timeout ? DONE : BUS)
            : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr_q         <= '0;
      dat_q         <= '0;
      sel_q         <= '0;
      we_q          <= 1'b0;
      f3_q          <= '0;
      off_q         <= '0;
      cnt           <= '0;
      err_q         <= 1'b0;
      o_read_data_M <= '0;
    end else begin
      if (state == IDLE && valid) begin
        adr_q <= {i_data_addr_M[DATA_WIDTH-1:2], 2'b00};
        dat_q <= dat_c;
        sel_q <= sel_c;
        we_q  <= i_mem_write_M;
        f3_q  <= i_funct3_MEM;
        off_q <= i_data_addr_M[1:0];
        cnt   <= '0;
      end
      if (state == BUS) begin
        cnt <= cnt + TO_WIDTH'(1);
        if (fail) begin
          err_q <= 1'b1;
          if (!we_q) o_read_data_M <= '0;
        end else if (i_wb_ack && !we_q) o_read_data_M <= load_c;
      end
      if (state == DONE) err_q <= 1'b0;
    end
  end
  // reset gating keeps the combinational flags quiet while rst is held low
  assign o_stall_M      = rst & ((state == IDLE & valid) | state == BUS);
  assign o_misaligned_M = rst & mis;
  assign o_bus_err_M    = state == DONE & err_q;
  assign o_wb_cyc       = state == BUS;
  assign o_wb_stb       = state == BUS;
  assign o_wb_we        = state == BUS & we_q;
  assign o_wb_sel       = state == BUS ? sel_q : 4'b0000;
  assign o_wb_adr       = adr_q;
  assign o_wb_dat       = dat_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random accesses checked against a byte-level
// reference model of the load/store unit.
module tb_load_store_unit;
  localparam int TO = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic rd = 1'b0, wr = 1'b0, ack = 1'b0, err = 1'b0;
  logic [2:0] f3 = '0;
  logic [31:0] addr = '0, wdata = '0, wbdat = '0;
  logic [31:0] read_data, wb_adr, wb_dat;
  logic stall, mis, bus_err, cyc, stb, we;
  logic [3:0] sel;
  int checks = 0, failures = 0;
  logic [31:0] rd_model = '0;

  load_store_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO), .TO_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .i_mem_read_M(rd), .i_mem_write_M(wr), .i_funct3_MEM(f3),
    .i_data_addr_M(addr), .i_write_data_M(wdata), .o_read_data_M(read_data),
    .o_stall_M(stall), .o_misaligned_M(mis), .o_bus_err_M(bus_err),
    .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we), .o_wb_sel(sel), .o_wb_adr(wb_adr),
    .o_wb_dat(wb_dat), .i_wb_dat(wbdat), .i_wb_ack(ack), .i_wb_err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f);
    return f[1] ? 4 : (f[0] ? 2 : 1);
  endfunction

  function automatic logic [31:0] fmt(input logic [2:0] f, input logic [1:0] off, input logic [31:0] d);
    int sz;
    logic [31:0] v, mask;
    sz = size_of(f);
    if (sz == 4) return d;
    mask = 32'((64'd1 << (8 * sz)) - 1);
    v = (d >> (8 * off)) & mask;
    if (!f[2] && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  // rsp: 0 ack, 1 err, 2 ack+err, 3 silent (timeout)
  task automatic access(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat, input int dly, input int rsp);
    int sz, n, expn;
    logic m, ld, bad;
    logic [31:0] ed;
    sz = size_of(f);
    m = (int'(a[1:0]) % sz) != 0;
    ld = r & ~w;
    bad = rsp != 0;
    for (int i = 0; i < 4; i++) ed[8*i +: 8] = wd[8*(i % sz) +: 8];
    @(negedge clk);
    rd = r; wr = w; f3 = f; addr = a; wdata = wd;
    #1;
    chk("misaligned", {31'd0, mis}, {31'd0, m});
    chk("stall_req", {31'd0, stall}, {31'd0, ~m});
    if (m) begin
      @(posedge clk); #1;
      chk("mis_no_cyc", {31'd0, cyc}, 32'd0);
      chk("mis_rdata", read_data, rd_model);
      rd = 1'b0; wr = 1'b0;
      return;
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    chk("we", {31'd0, we}, {31'd0, w});
    chk("sel", {28'd0, sel}, {28'd0, 4'(((1 << sz) - 1) << a[1:0])});
    chk("adr", wb_adr, a & 32'hFFFF_FFFC);
    if (w) chk("dat", wb_dat, ed);
    n = 0;
    while (1) begin
      chk("cyc_bus", {31'd0, cyc & stb}, 32'd1);
      chk("stall_bus", {31'd0, stall}, 32'd1);
      if (rsp != 3 && n == dly) begin
        ack = rsp != 1; err = rsp != 0; wbdat = rdat;
      end
      @(posedge clk); #1;
      ack = 1'b0; err = 1'b0;
      n++;
      if (!cyc || n > 40) break;
    end
    expn = rsp == 3 ? TO : dly + 1;
    chk("bus_cycles", n, expn);
    if (ld) rd_model = bad ? 32'd0 : fmt(f, a[1:0], rdat);
    chk("done_stb", {31'd0, stb}, 32'd0);
    chk("done_stall", {31'd0, stall}, 32'd0);
    chk("done_err", {31'd0, bus_err}, {31'd0, bad});
    chk("done_rdata", read_data, rd_model);
    @(posedge clk); #1;
    chk("err_pulse", {31'd0, bus_err}, 32'd0);
  endtask

  initial begin
    #2;
    chk("rst_rdata", read_data, 32'd0);
    chk("rst_adr", wb_adr, 32'd0);
    chk("rst_dat", wb_dat, 32'd0);
    chk("rst_ctl", {25'd0, cyc, stb, we, sel}, 32'd0);
    chk("rst_flags", {29'd0, stall, mis, bus_err}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1, 0);
    access(0, 1, 3'b000, 32'h101, 32'h000000AB, 32'h0, 0, 0);
    access(0, 1, 3'b001, 32'h102, 32'h00001234, 32'h0, 0, 0);
    access(1, 0, 3'b000, 32'h200, 32'h0, 32'h80017F80, 0, 0);
    chk("lb_200", read_data, 32'hFFFFFF80);
    access(1, 0, 3'b100, 32'h200, 32'h0, 32'h80017F80, 0, 0);
    chk("lbu_200", read_data, 32'h00000080);
    access(1, 0, 3'b000, 32'h201, 32'h0, 32'h80017F80, 1, 0);
    chk("lb_201", read_data, 32'h0000007F);
    access(1, 0, 3'b001, 32'h202, 32'h0, 32'h80017F80, 0, 0);
    chk("lh_202", read_data, 32'hFFFF8001);
    access(1, 0, 3'b101, 32'h202, 32'h0, 32'h80017F80, 2, 0);
    chk("lhu_202", read_data, 32'h00008001);
    access(1, 0, 3'b010, 32'h200, 32'h0, 32'h80017F80, 0, 0);
    chk("lw_200", read_data, 32'h80017F80);
    access(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0);
    access(0, 1, 3'b001, 32'h101, 32'h5555, 32'h0, 0, 0);
    chk("mis_keep", read_data, 32'h80017F80);
    access(1, 0, 3'b010, 32'h204, 32'h0, 32'h0, 0, 3);
    chk("timeout_rdata", read_data, 32'd0);
    access(1, 0, 3'b010, 32'h208, 32'h0, 32'h12345678, 0, 0);
    access(1, 0, 3'b010, 32'h20C, 32'h0, 32'hCAFEF00D, 1, 2);
    access(1, 1, 3'b010, 32'h210, 32'h11223344, 32'h0, 0, 0);
    // reset in the middle of a bus cycle
    @(negedge clk);
    rd = 1'b1; f3 = 3'b010; addr = 32'h400;
    @(posedge clk); #1;
    rd = 1'b0;
    chk("pre_rst_cyc", {31'd0, cyc}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_ctl", {25'd0, cyc, stb, we, sel}, 32'd0);
    chk("mid_rst_stall", {29'd0, stall, mis, bus_err}, 32'd0);
    chk("mid_rst_data", read_data | wb_adr | wb_dat, 32'd0);
    rd_model = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    access(1, 0, 3'b010, 32'h300, 32'h0, 32'hA5A5_0F0F, 0, 0);
    access(1, 0, 3'b010, 32'h304, 32'h0, 32'h0BAD_F00D, 0, 0);
    for (int k = 0; k < 150; k++) begin
      logic r, w;
      r = 1'($urandom); w = 1'($urandom);
      if (!r && !w) r = 1'b1;
      access(r, w, 3'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, 2)),
             int'($urandom_range(0, 3)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
